// File: rtl/led_driver_array.sv
// led_driver_array: N-channel LED driver with const/blink/PWM modes and boundary-synchronised config writes
// Optional feature macro: LED_DRV_BLINK_EN (blink mode, prescaler, blink phase); undefined -> mode 10 drives 0.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   wr_en     configuration write request
//   wr_ch     target channel (values >= N are accepted then discarded)
//   wr_mode   00 const0, 01 const1, 10 blink, 11 PWM
//   wr_duty   PWM duty, used only with mode 11
//   wr_ready  high when the single pending slot is empty
//   led       registered channel outputs
module led_driver_array #(
    parameter int N = 5,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 12000000,
    parameter logic [N-1:0] RESET_PATTERN = N'(5'b01111),
    localparam int CW = N > 1 ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_ch,
    input  logic [1:0]          wr_mode,
    input  logic [PWM_BITS-1:0] wr_duty,
    output logic                wr_ready,
    output logic [N-1:0]        led
);
    logic [PWM_BITS-1:0] cnt;
    logic                pend;
    logic [CW-1:0]       p_ch;
    logic [1:0]          p_mode;
    logic [PWM_BITS-1:0] p_duty;
    logic [1:0]          mode [N];
    logic [PWM_BITS-1:0] duty [N];
    logic                phase;
    logic [N-1:0]        nxt;
    logic                apply;

    assign wr_ready = ~pend;
    // only a write already pending when the wrap cycle starts is applied in it
    assign apply = pend & (&cnt);

`ifdef LED_DRV_BLINK_EN
    localparam int PW = $clog2(PRESCALE);
    logic [PW-1:0] pre;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre   <= '0;
            phase <= 1'b0;
        end else if (pre == PW'(PRESCALE - 1)) begin
            pre   <= '0;
            phase <= ~phase;
        end else begin
            pre <= pre + 1'b1;
        end
    end
`else
    assign phase = 1'b0;
`endif

    // the applying write is bypassed into the output decode so led follows one cycle after the boundary
    for (genvar i = 0; i < N; i++) begin : g_ch
        logic                hit;
        logic [1:0]          em;
        logic [PWM_BITS-1:0] ed;
        assign hit    = apply && p_ch == CW'(i);
        assign em     = hit ? p_mode : mode[i];
        assign ed     = hit && p_mode == 2'b11 ? p_duty : duty[i];
        assign nxt[i] = em[1] ? (em[0] ? cnt < ed : phase) : em[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            pend   <= 1'b0;
            p_ch   <= '0;
            p_mode <= '0;
            p_duty <= '0;
            led    <= RESET_PATTERN;
            for (int i = 0; i < N; i++) begin
                mode[i] <= {1'b0, RESET_PATTERN[i]};
                duty[i] <= '0;
            end
        end else begin
            cnt <= cnt + 1'b1;
            led <= nxt;
            if (wr_en && !pend) begin
                pend   <= 1'b1;
                p_ch   <= wr_ch;
                p_mode <= wr_mode;
                p_duty <= wr_duty;
            end else if (apply) begin
                pend <= 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (apply && p_ch == CW'(i)) begin
                    mode[i] <= p_mode;
                    if (p_mode == 2'b11) duty[i] <= p_duty;
                end
            end
        end
    end
endmodule

// File: tb/tb_led_driver_array.sv
// tb_led_driver_array: table, directed and random checks of led_driver_array against a cycle-count model
module tb_led_driver_array;
    localparam logic [4:0] RP = 5'b01111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_ch = '0;
    logic [1:0] wr_mode = '0;
    logic [3:0] wr_duty = '0;
    logic       wr_ready;
    logic [4:0] led;

    int vectors = 0;
    int miscompares = 0;

    led_driver_array #(.N(5), .PWM_BITS(4), .PRESCALE(8), .RESET_PATTERN(RP)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
        .wr_duty(wr_duty), .wr_ready(wr_ready), .led(led)
    );

    always #5 clk = ~clk;

    int         m_k;
    bit         m_pend;
    int         m_ch;
    int         m_md;
    int         m_dt;
    int         m_mode [5];
    int         m_duty [5];
    logic [4:0] m_led;

    typedef struct {
        logic [2:0] ch;
        logic [1:0] md;
        logic [3:0] dt;
        logic [4:0] exp;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_k = 0;
        m_pend = 0;
        m_led = RP;
        for (int i = 0; i < 5; i++) begin
            m_mode[i] = RP[i] ? 1 : 0;
            m_duty[i] = 0;
        end
    endtask

    // spec-level view: counter = cycles since reset mod 16, blink phase = (cycles/8) mod 2
    task automatic model_tick();
        int  c;
        bit  ph;
        c = m_k % 16;
`ifdef LED_DRV_BLINK_EN
        ph = ((m_k / 8) % 2) == 1;
`else
        ph = 0;
`endif
        if (m_pend && c == 15) begin
            if (m_ch < 5) begin
                m_mode[m_ch] = m_md;
                if (m_md == 3) m_duty[m_ch] = m_dt;
            end
            m_pend = 0;
        end else if (wr_en && !m_pend) begin
            m_pend = 1;
            m_ch = int'(wr_ch);
            m_md = int'(wr_mode);
            m_dt = int'(wr_duty);
        end
        for (int i = 0; i < 5; i++)
            m_led[i] = m_mode[i] == 0 ? 1'b0 : m_mode[i] == 1 ? 1'b1 : m_mode[i] == 2 ? ph : (c < m_duty[i]);
        m_k++;
    endtask

    task automatic step(input logic we, input logic [2:0] ch, input logic [1:0] md, input logic [3:0] dt);
        wr_en = we;
        wr_ch = ch;
        wr_mode = md;
        wr_duty = dt;
        @(posedge clk);
        model_tick();
        @(negedge clk);
        wr_en = 1'b0;
        chk("led", 32'(led), 32'(m_led));
        chk("wr_ready", 32'(wr_ready), 32'(!m_pend));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 2'd0, 4'd0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!wr_ready && n < 40) begin
            step(1'b0, 3'd0, 2'd0, 4'd0);
            n++;
        end
        if (!wr_ready) begin
            miscompares++;
            $display("FAIL wait_ready: wr_ready still 0 after %0d cycles", n);
        end
    endtask

    task automatic write(input logic [2:0] ch, input logic [1:0] md, input logic [3:0] dt);
        wait_ready();
        step(1'b1, ch, md, dt);
        wait_ready();
    endtask

    // reset asserted between clock edges; outputs must change before any edge
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_led", 32'(led), 32'(RP));
        chk("async_rst_ready", 32'(wr_ready), 32'd1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int ones;
        int toggles;
        logic prev;
        tbl[0] = '{3'd4, 2'b01, 4'd0, 5'b11111};
        tbl[1] = '{3'd0, 2'b00, 4'd9, 5'b11110};
        tbl[2] = '{3'd7, 2'b01, 4'd0, 5'b11110};
        tbl[3] = '{3'd2, 2'b00, 4'd0, 5'b11010};
        tbl[4] = '{3'd0, 2'b01, 4'd3, 5'b11011};
        tbl[5] = '{3'd3, 2'b11, 4'd0, 5'b10011};
        tbl[6] = '{3'd4, 2'b00, 4'd0, 5'b00011};

        model_reset();
        @(negedge clk);
        chk("reset_led", 32'(led), 32'(RP));
        chk("reset_ready", 32'(wr_ready), 32'd1);
        rst_n = 1'b1;

        for (int t = 0; t < 7; t++) begin
            write(tbl[t].ch, tbl[t].md, tbl[t].dt);
            chk($sformatf("table%0d", t), 32'(led), 32'(tbl[t].exp));
        end

        // write ch4 const1 at counter 3, applied after the count-15 boundary
        do_reset();
        idle(3);
        step(1'b1, 3'd4, 2'b01, 4'd0);
        for (int j = 0; j < 12; j++) begin
            step(1'b0, 3'd0, 2'd0, 4'd0);
            chk("c30_ready", 32'(wr_ready), 32'(j == 11));
            chk("c30_led4", 32'(led[4]), 32'(j == 11));
        end

        // PWM duty 4: four high cycles per 16
        write(3'd0, 2'b11, 4'd4);
        ones = 0;
        for (int j = 0; j < 48; j++) begin
            step(1'b0, 3'd0, 2'd0, 4'd0);
            ones += int'(led[0]);
        end
        chk("pwm_duty4_ones", 32'(ones), 32'd12);

        // PWM duty 15: one low cycle per period
        write(3'd3, 2'b11, 4'd15);
        ones = 0;
        for (int j = 0; j < 32; j++) begin
            step(1'b0, 3'd0, 2'd0, 4'd0);
            ones += int'(led[3]);
        end
        chk("pwm_duty15_ones", 32'(ones), 32'd30);

        // blink on ch1
        write(3'd1, 2'b10, 4'd0);
        prev = led[1];
        toggles = 0;
        ones = 0;
        for (int j = 0; j < 32; j++) begin
            step(1'b0, 3'd0, 2'd0, 4'd0);
            toggles += int'(led[1] != prev);
            ones += int'(led[1]);
            prev = led[1];
        end
`ifdef LED_DRV_BLINK_EN
        chk("blink_toggles", 32'(toggles), 32'd4);
        chk("blink_ones", 32'(ones), 32'd16);
`else
        chk("blink_toggles", 32'(toggles), 32'd0);
        chk("blink_ones", 32'(ones), 32'd0);
`endif

        // reset discards a pending write
        do_reset();
        idle(2);
        step(1'b1, 3'd2, 2'b00, 4'd0);
        idle(3);
        do_reset();
        idle(40);
        chk("rst_discard_led2", 32'(led[2]), 32'd1);
        chk("rst_discard_led", 32'(led), 32'(RP));

        // random traffic against the model
        for (int j = 0; j < 400; j++)
            step(($urandom % 3) == 0, 3'($urandom_range(0, 7)), 2'($urandom), 4'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/led_driver_array.md
LED_DRIVER_ARRAY -- requirements
Module: led_driver_array

Interface
REQ-001 Parameter N, default 5: number of output channels, 1..32.
REQ-002 Parameter PWM_BITS, default 8: PWM counter and duty width, 2..16.
REQ-003 Parameter PRESCALE, default 12000000: clock cycles per blink half-period, at least 2.
REQ-004 Parameter RESET_PATTERN, default N'b01111: per-channel constant level applied at reset.
REQ-005 Port clk, input, 1: single clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous reset, active-low.
REQ-007 Port wr_en, input, 1: configuration write request.
REQ-008 Port wr_ch, input, max(1,clog2(N)): target channel.
REQ-009 Port wr_mode, input, 2: channel mode: 00 const0, 01 const1, 10 blink, 11 PWM.
REQ-010 Port wr_duty, input, PWM_BITS: PWM duty; ignored unless wr_mode=11.
REQ-011 Port wr_ready, output, 1: high when a write can be accepted.
REQ-012 Port led, output, N: registered channel outputs.

Function
REQ-013 Free-running PWM counter: 0..2^PWM_BITS-1, +1 per cycle; wraps to 0.
REQ-014 Wrap boundary: the cycle in which the PWM counter equals 2^PWM_BITS-1.
REQ-015 Prescaler: counts 0..PRESCALE-1; blink phase toggles in the cycle it equals PRESCALE-1; prescaler then returns to 0.
REQ-016 Each led[i] SHALL be registered, computed from the channel mode and the current counter/phase, one cycle latency.
  - const0: 0
  - const1: 1
  - blink: blink phase
  - PWM: (PWM counter < duty)
REQ-017 PWM duty=0 SHALL give constant 0; duty=2^PWM_BITS-1 SHALL give low one cycle per period.
REQ-018 All blink-mode channels SHALL share one phase (in step).
REQ-019 A write is accepted when wr_en=1 and wr_ready=1; ch/mode/duty are captured into a single pending slot, and wr_ready=0 from the next cycle.
REQ-020 The pending write SHALL be applied to the channel configuration at the next wrap boundary (glitch-free PWM); wr_ready=1 again the following cycle.
  - A write accepted in the wrap-boundary cycle itself SHALL wait for the following boundary.
REQ-021 wr_en while wr_ready=0 SHALL be ignored with no side effect.
REQ-022 wr_ch >= N: the write is accepted and follows normal handshake timing, but is discarded at the boundary with no channel change.
REQ-023 A mode change SHALL reset no counters; the new mode takes effect on led one cycle after the boundary.

Reset
REQ-024 rst_n=0 SHALL asynchronously set every register to its reset value:
  - PWM counter, prescaler and blink phase to 0
  - pending slot empty; wr_ready=1
  - channel i mode const1 if RESET_PATTERN[i]=1, else const0; duty 0
  - led=RESET_PATTERN
REQ-025 Reset during a pending write SHALL discard the pending write.
REQ-026 Release SHALL be synchronous to clk; this is the integrator's responsibility.

Configuration
REQ-027 Macro LED_DRV_BLINK_EN defined: blink mode, prescaler and blink phase are present as specified.
REQ-028 LED_DRV_BLINK_EN undefined: prescaler and phase are not implemented; mode 10 SHALL behave as const0; all other behaviour is unchanged.

Verification (N=5, PWM_BITS=4, PRESCALE=8, macro defined unless noted)
REQ-029 Assert rst_n=0 mid-cycle -> led=5'b01111 and wr_ready=1 immediately, with no clock edge required.
REQ-030 Write ch4 mode01 at PWM count 3 -> wr_ready=0 until boundary at count 15; led[4]=1 one cycle after boundary; wr_ready=1 that same cycle.
REQ-031 Write ch0 mode11 duty4 -> after apply, led[0] high exactly 4 of every 16 cycles, repeated for at least 3 periods.
REQ-032 Write ch1 mode10 -> led[1] toggles every 8 cycles; rebuilt without LED_DRV_BLINK_EN -> led[1]=0 constantly.
REQ-033 Write ch=7 mode01 -> normal wr_ready low/high sequence; led unchanged at 5'b01111.
REQ-034 Accept write ch2 mode00, assert rst_n=0 before the boundary -> led[2] stays 1 after reset release; no late apply at later boundaries.
